pkt_tx_framer: RTL



---
 rtl/pkt_tx_framer_if.sv | 41 ++++
 rtl/pkt_tx_framer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_framer_if.sv
// -----------------------------------------------------------------------------
// pkt_tx_framer_if
//   Byte-side handshake and serial RF-side signals of the packet transmit
//   framer. The master modport belongs to the byte source / bit-rate timing
//   (the SPI side); the slave modport belongs to the framer.
// -----------------------------------------------------------------------------
interface pkt_tx_framer_if;
    logic [7:0] din;        // payload byte
    logic       din_valid;  // din holds a valid byte
    logic       din_ready;  // framer can accept a byte this cycle
    logic       abort;      // synchronous abort of the current packet
    logic       bit_en;     // one-cycle bit-rate strobe
    logic       tx_out;     // serial RF data out
    logic       tx_active;  // high while sync + payload are being driven
    logic       pkt_sent;   // one-cycle pulse at end of frame
    logic [3:0] fill_cnt;   // bytes accepted for the current packet

    modport master (
        output din,
        output din_valid,
        output abort,
        output bit_en,
        input  din_ready,
        input  tx_out,
        input  tx_active,
        input  pkt_sent,
        input  fill_cnt
    );

    modport slave (
        input  din,
        input  din_valid,
        input  abort,
        input  bit_en,
        output din_ready,
        output tx_out,
        output tx_active,
        output pkt_sent,
        output fill_cnt
    );
endinterface : pkt_tx_framer_if

// File: rtl/pkt_tx_framer.sv
// -----------------------------------------------------------------------------
// pkt_tx_framer
//   Transmit-side packet framer. Collects PKT_BYTES payload bytes over a
//   valid/ready handshake, prepends a SYNC_W-bit sync word and shifts the
//   frame out MSB-first, one bit per bit_en strobe, followed by GAP_BITS
//   strobes of forced idle (tx_out=0).
//
//   Optional feature: define PKT_TX_PARITY_EN to append one even-parity bit
//   (XOR of all payload bits, sync excluded) after the last payload bit,
//   with tx_active still high.
//
//   Reset is synchronous and active-high. abort behaves like reset for the
//   packet state: the framer returns to IDLE and partial bytes are dropped.
// -----------------------------------------------------------------------------
module pkt_tx_framer #(
    parameter int unsigned       PKT_BYTES = 8,
    parameter int unsigned       SYNC_W    = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hA5C3,
    parameter int unsigned       GAP_BITS  = 4
) (
    input  logic           clk,
    input  logic           rst,
    pkt_tx_framer_if.slave tx_bus
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int unsigned PAY_W   = PKT_BYTES * 8;
    localparam int unsigned FRAME_W = SYNC_W + PAY_W;
`ifdef PKT_TX_PARITY_EN
    localparam int unsigned FRAME_LEN = FRAME_W + 1;
`else
    localparam int unsigned FRAME_LEN = FRAME_W;
`endif
    localparam int unsigned CNT_W = $clog2(SYNC_W + PAY_W + 2);

    // Bit counter values that trigger state changes
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);
    localparam logic [3:0]       LAST_FILL = 4'(PKT_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [FRAME_W-1:0] r_sr;         // {sync, byte0 .. byteN-1}, MSB leaves first
    logic [CNT_W-1:0]   r_bit_cnt;    // strobes in frame, or strobes in gap
    logic [3:0]         r_fill_cnt;
    logic               r_din_ready;
    logic               r_tx_out;
    logic               r_tx_active;
    logic               r_pkt_sent;
`ifdef PKT_TX_PARITY_EN
    logic               r_parity;     // running XOR of accepted payload bytes
`endif

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic             w_xfer;
    logic             w_last_byte;
    logic [PAY_W-1:0] w_pay_next;
    logic             w_next_bit;

    // din_ready is only ever high in IDLE/FILL, so a handshake implies one of
    // those states.
    assign w_xfer      = tx_bus.din_valid && r_din_ready;
    assign w_last_byte = w_xfer && (r_fill_cnt == LAST_FILL);

    // Payload with the incoming byte appended at the LSB end; after the last
    // byte, byte0 has been pushed up to the most significant payload position.
    assign w_pay_next = PAY_W'({r_sr[PAY_W-1:0], tx_bus.din});

`ifdef PKT_TX_PARITY_EN
    // Once every sync and payload bit has left, the parity bit is driven.
    assign w_next_bit = (r_bit_cnt == CNT_W'(FRAME_W)) ? r_parity : r_sr[FRAME_W-1];
`else
    assign w_next_bit = r_sr[FRAME_W-1];
`endif

    // -------------------------------------------------------------------------
    // Framer FSM: byte collection, serialization, gap and abort handling
    // -------------------------------------------------------------------------
    // NOTE: every state register here uses non-blocking assignment so all of
    // them update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || tx_bus.abort) begin
            // NOTE: the shift register is cleared too, so a dropped partial
            // packet can never leak bytes into the next frame.
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_fill_cnt  <= '0;
            r_din_ready <= 1'b0;
            r_tx_out    <= 1'b0;
            r_tx_active <= 1'b0;
            r_pkt_sent  <= 1'b0;
`ifdef PKT_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_pkt_sent <= 1'b0;

            case (r_state)
                // Accept bytes; bit_en is ignored until the frame is loaded.
                ST_IDLE, ST_FILL: begin
                    r_din_ready <= !w_last_byte;
                    if (w_xfer) begin
                        r_fill_cnt <= r_fill_cnt + 4'd1;
`ifdef PKT_TX_PARITY_EN
                        r_parity   <= r_parity ^ (^tx_bus.din);
`endif
                        if (w_last_byte) begin
                            // Load the full frame; a strobe in this same cycle
                            // is not consumed because the state is not SYNC yet.
                            r_sr    <= {SYNC_WORD, w_pay_next};
                            r_state <= ST_SYNC;
                        end else begin
                            r_sr    <= {{SYNC_W{1'b0}}, w_pay_next};
                            r_state <= ST_FILL;
                        end
                    end
                end

                // Shift the frame out, one bit per strobe.
                ST_SYNC, ST_DATA: begin
                    if (tx_bus.bit_en) begin
                        if (r_bit_cnt == FRAME_END) begin
                            // Every frame bit has had its full strobe period.
                            r_tx_out    <= 1'b0;
                            r_tx_active <= 1'b0;
                            r_pkt_sent  <= 1'b1;
                            r_fill_cnt  <= '0;
                            r_bit_cnt   <= '0;
                            r_state     <= ST_GAP;
`ifdef PKT_TX_PARITY_EN
                            r_parity    <= 1'b0;
`endif
                        end else begin
                            r_tx_out    <= w_next_bit;
                            r_tx_active <= 1'b1;
                            r_sr        <= r_sr << 1;
                            r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
                            if (r_state == ST_SYNC && r_bit_cnt == SYNC_LAST) begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                end

                // Hold the line idle for GAP_BITS strobes before the next packet.
                ST_GAP: begin
                    if (tx_bus.bit_en) begin
                        if (r_bit_cnt == GAP_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all driven straight from registers
    // -------------------------------------------------------------------------
    assign tx_bus.din_ready = r_din_ready;
    assign tx_bus.tx_out    = r_tx_out;
    assign tx_bus.tx_active = r_tx_active;
    assign tx_bus.pkt_sent  = r_pkt_sent;
    assign tx_bus.fill_cnt  = r_fill_cnt;

endmodule : pkt_tx_framer
